// File: rtl/usb_reg_ctrl.sv
// Register bank, capture FIFO and capture sequencer behind the EPP-style USB address/data window.
// Define USB_REG_OVF_CNT_EN to build the dropped-sample counter readable at 0x0A.
module usb_reg_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] usbIF_address,
  input  logic                  usbIF_data_write,
  input  logic [DATA_WIDTH-1:0] usbIF_data_out,
  input  logic                  usbIF_data_read,
  output logic [DATA_WIDTH-1:0] usbIF_data_in,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] cfg0,
  output logic [DATA_WIDTH-1:0] cfg1,
  output logic                  capture_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = DATA_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_COUNT  = ADDR_WIDTH'(8'h01);
  localparam logic [ADDR_WIDTH-1:0] A_USER0  = ADDR_WIDTH'(8'h02);
  localparam logic [ADDR_WIDTH-1:0] A_USER1  = ADDR_WIDTH'(8'h03);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_LEVEL  = ADDR_WIDTH'(8'h09);
  localparam logic [ADDR_WIDTH-1:0] A_FIFO   = ADDR_WIDTH'(8'h10);
`ifdef USB_REG_OVF_CNT_EN
  localparam logic [ADDR_WIDTH-1:0] A_OVFC   = ADDR_WIDTH'(8'h0A);
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  run_q, run_d;
  logic                  single_q, single_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [DATA_WIDTH-1:0] count_q, user0_q, user1_q;
  logic                  ovf_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH-1:0] data_in_q, rd_mux;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] level_disp, status_val, ctrl_val;

  logic wr_ctrl, wr_count, wr_user0, wr_user1, wr_status;
  logic fifo_clr, empty, full, smp, pop, push, drop;

  assign wr_ctrl   = usbIF_data_write && (usbIF_address == A_CTRL);
  assign wr_count  = usbIF_data_write && (usbIF_address == A_COUNT);
  assign wr_user0  = usbIF_data_write && (usbIF_address == A_USER0);
  assign wr_user1  = usbIF_data_write && (usbIF_address == A_USER1);
  assign wr_status = usbIF_data_write && (usbIF_address == A_STATUS);
  assign fifo_clr  = wr_ctrl && usbIF_data_out[2];

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign smp   = (state_q == S_CAPTURE) && sample_valid;
  assign pop   = usbIF_data_read && (usbIF_address == A_FIFO) && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
  assign push  = smp && (!full || pop);
  assign drop  = smp && full && !pop;

  // RUN decisions use the incoming write so the FSM reacts one cycle after the strobe.
  always_comb begin
    run_d    = run_q;
    single_d = single_q;
    state_d  = state_q;
    rem_d    = rem_q;
    if (wr_ctrl) begin
      run_d    = usbIF_data_out[0];
      single_d = usbIF_data_out[1];
    end
    case (state_q)
      S_IDLE: begin
        if (run_d) begin
          state_d = S_CAPTURE;
          rem_d   = (count_q == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, count_q};
        end
      end
      S_CAPTURE: begin
        if (single_q && smp) rem_d = rem_q - 1'b1;
        if (!run_d) state_d = S_IDLE;
        else if (single_q && smp && (rem_q == RW'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!wr_ctrl) run_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      single_q <= 1'b0;
      rem_q    <= '0;
      count_q  <= '0;
      user0_q  <= '0;
      user1_q  <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_in_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      single_q <= single_d;
      rem_q    <= rem_d;
      if (wr_count) count_q <= usbIF_data_out;
      if (wr_user0) user0_q <= usbIF_data_out;
      if (wr_user1) user1_q <= usbIF_data_out;
      if (drop) ovf_q <= 1'b1;
      else if (wr_status && usbIF_data_out[2]) ovf_q <= 1'b0;
      if (fifo_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
      data_in_q <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_data;
  end

`ifdef USB_REG_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else if (fifo_clr || (usbIF_data_write && (usbIF_address == A_OVFC))) ovf_cnt_q <= '0;
    else if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
  end
`endif

  generate
    if (LW > DATA_WIDTH) begin : g_level_sat
      assign level_disp = (|level_q[LW-1:DATA_WIDTH]) ? '1 : level_q[DATA_WIDTH-1:0];
    end else begin : g_level_ext
      assign level_disp = DATA_WIDTH'(level_q);
    end
  endgenerate

  always_comb begin
    status_val    = '0;
    status_val[0] = empty;
    status_val[1] = full;
    status_val[2] = ovf_q;
    status_val[3] = (state_q != S_IDLE);
    ctrl_val      = '0;
    ctrl_val[0]   = run_q;
    ctrl_val[1]   = single_q;
  end

  always_comb begin
    rd_mux = '0;
    case (usbIF_address)
      A_CTRL:   rd_mux = ctrl_val;
      A_COUNT:  rd_mux = count_q;
      A_USER0:  rd_mux = user0_q;
      A_USER1:  rd_mux = user1_q;
      A_STATUS: rd_mux = status_val;
      A_LEVEL:  rd_mux = level_disp;
      A_FIFO:   rd_mux = empty ? '0 : mem_q[rd_ptr_q];
`ifdef USB_REG_OVF_CNT_EN
      A_OVFC:   rd_mux = DATA_WIDTH'(ovf_cnt_q);
`endif
      default:  rd_mux = '0;
    endcase
  end

  assign usbIF_data_in = data_in_q;
  assign sample_ready  = (state_q == S_CAPTURE);
  assign capture_busy  = (state_q != S_IDLE);
  assign cfg0          = user0_q;
  assign cfg1          = user1_q;

endmodule

// File: tb/tb_usb_reg_ctrl.sv
// Scoreboard bench for usb_reg_ctrl: stimulus queues expected values, a negedge monitor compares.
module tb_usb_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] address;
  logic       data_write;
  logic [7:0] data_out;
  logic       data_read;
  logic [7:0] data_in;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic [7:0] cfg0, cfg1;
  logic       busy;

  always #5 clk = ~clk;

  usb_reg_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .usbIF_address(address), .usbIF_data_write(data_write), .usbIF_data_out(data_out),
    .usbIF_data_read(data_read), .usbIF_data_in(data_in),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .cfg0(cfg0), .cfg1(cfg1), .capture_busy(busy)
  );

`ifdef USB_REG_OVF_CNT_EN
  localparam logic [7:0] OVFC_EXP = 8'd4;
`else
  localparam logic [7:0] OVFC_EXP = 8'd0;
`endif

  // sel: 0 data_in, 1 cfg0, 2 cfg1, 3 sample_ready, 4 capture_busy
  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t q[$];
  logic chk_valid = 1'b0;
  int   total = 0;
  int   bad = 0;

  always @(negedge clk) begin
    if (chk_valid) begin
      chk_t c;
      logic [7:0] act;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL monitor_underflow: check strobe with no expected value queued");
      end else begin
        c = q.pop_front();
        case (c.sel)
          0: act = data_in;
          1: act = cfg0;
          2: act = cfg1;
          3: act = {7'b0, sample_ready};
          default: act = {7'b0, busy};
        endcase
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sel, input logic [7:0] e, input string n);
    chk_t c;
    c.sel = sel; c.exp = e; c.name = n;
    q.push_back(c);
    chk_valid = 1'b1;
    tick();
    chk_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string n);
    address = a;
    tick();
    expect_sig(0, e, n);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; data_out = d; data_write = 1'b1;
    tick();
    data_write = 1'b0;
  endtask

  task automatic samp(input logic [7:0] d);
    sample_data = d; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pop();
    address = 8'h10; data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; address = '0; data_write = 1'b0; data_out = '0;
    data_read = 1'b0; sample_data = '0; sample_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // reset state
    rd(8'h00, 8'h00, "ctrl_reset");
    rd(8'h08, 8'h01, "status_reset");
    rd(8'h09, 8'h00, "level_reset");
    rd(8'h10, 8'h00, "fifo_empty_reset");
    rd(8'h0A, 8'h00, "ovfc_reset");
    expect_sig(1, 8'h00, "cfg0_reset");
    expect_sig(2, 8'h00, "cfg1_reset");
    expect_sig(4, 8'h00, "busy_reset");
    expect_sig(3, 8'h00, "ready_reset");

    // user registers
    wr(8'h02, 8'hA5);
    expect_sig(1, 8'hA5, "cfg0_write");
    wr(8'h03, 8'h3C);
    expect_sig(2, 8'h3C, "cfg1_write");
    rd(8'h02, 8'hA5, "user0_readback");
    rd(8'h03, 8'h3C, "user1_readback");

    // single-shot of five samples
    wr(8'h01, 8'h05);
    rd(8'h01, 8'h05, "count_readback");
    wr(8'h00, 8'h03);
    expect_sig(3, 8'h01, "ready_after_run");
    expect_sig(4, 8'h01, "busy_after_run");
    rd(8'h00, 8'h03, "ctrl_running");
    for (int i = 0; i < 5; i++) samp(8'h10 + 8'(i));
    expect_sig(4, 8'h01, "busy_in_done");
    expect_sig(4, 8'h00, "busy_idle_after_done");
    rd(8'h00, 8'h02, "ctrl_run_cleared");
    rd(8'h09, 8'h05, "level_single");
    rd(8'h08, 8'h00, "status_single");
    for (int i = 0; i < 5; i++) begin
      rd(8'h10, 8'h10 + 8'(i), "fifo_single_pop");
      pop();
    end
    rd(8'h08, 8'h01, "status_drained");
    rd(8'h10, 8'h00, "fifo_drained_reads0");

    // continuous run overflowing the FIFO
    wr(8'h00, 8'h01);
    for (int i = 0; i < 20; i++) samp(8'h20 + 8'(i));
    wr(8'h00, 8'h00);
    expect_sig(4, 8'h00, "busy_stopped");
    rd(8'h09, 8'h10, "level_full");
    rd(8'h08, 8'h06, "status_full_ovf");
    rd(8'h0A, OVFC_EXP, "ovf_count");
    wr(8'h08, 8'h04);
    rd(8'h08, 8'h02, "status_ovf_cleared");

    // push and pop together while full
    wr(8'h00, 8'h01);
    address = 8'h10; data_read = 1'b1; sample_data = 8'h55; sample_valid = 1'b1;
    tick();
    data_read = 1'b0; sample_valid = 1'b0;
    wr(8'h00, 8'h00);
    rd(8'h09, 8'h10, "level_pushpop");
    rd(8'h08, 8'h02, "status_pushpop");
    rd(8'h0A, OVFC_EXP, "ovf_count_pushpop");
    for (int i = 0; i < 16; i++) begin
      rd(8'h10, (i < 15) ? 8'h21 + 8'(i) : 8'h55, "fifo_wrap_pop");
      pop();
    end
    rd(8'h08, 8'h01, "status_wrap_drained");

    // FIFO_CLR concurrent with a sample
    wr(8'h00, 8'h01);
    samp(8'h60); samp(8'h61); samp(8'h62);
    rd(8'h09, 8'h03, "level_pre_clr");
    address = 8'h00; data_out = 8'h05; data_write = 1'b1;
    sample_data = 8'h63; sample_valid = 1'b1;
    tick();
    data_write = 1'b0; sample_valid = 1'b0;
    rd(8'h09, 8'h00, "level_clr");
    rd(8'h08, 8'h09, "status_clr");
    rd(8'h00, 8'h01, "ctrl_clr_reads0");
    rd(8'h0A, 8'h00, "ovfc_after_clr");
    samp(8'h70);
    rd(8'h09, 8'h01, "level_after_clr_push");
    rd(8'h10, 8'h70, "fifo_after_clr");

    // reset mid-capture
    rd(8'h02, 8'hA5, "user0_pre_reset");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_sig(0, 8'h00, "data_in_reset");
    expect_sig(4, 8'h00, "busy_mid_reset");
    expect_sig(3, 8'h00, "ready_mid_reset");
    expect_sig(1, 8'h00, "cfg0_mid_reset");
    expect_sig(2, 8'h00, "cfg1_mid_reset");
    rd(8'h00, 8'h00, "ctrl_mid_reset");
    rd(8'h01, 8'h00, "count_mid_reset");
    rd(8'h08, 8'h01, "status_mid_reset");
    rd(8'h09, 8'h00, "level_mid_reset");

    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
